// File: rtl/bnn_argmax_head.sv
// Binarized-network output head: captures a hidden-layer activation vector, scores K
// classes one per cycle by XNOR-popcount and reports the arg-max class and its score.
module bnn_argmax_head #(
    parameter int unsigned M = 4,
    parameter int unsigned K = 4,
    parameter logic [K*M-1:0] W = '0,
    localparam int unsigned SW = $clog2(M + 1),
    localparam int unsigned CW = (K > 1) ? $clog2(K) : 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_valid,
    input  logic [M-1:0]  in_bits,
    output logic          in_ready,
    output logic          busy,
    output logic [CW-1:0] class_out,
    output logic [SW-1:0] score_out,
    output logic          out_valid,
    output logic          overrun
);

    localparam int unsigned NW = 2 ** CW;

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] SCORE = 2'd1;
    localparam logic [1:0] DONE  = 2'd2;

    logic [1:0]    state_q, state_d;
    logic          prev_valid_q, prev_valid_d;
    logic [M-1:0]  x_q, x_d;
    logic [CW-1:0] k_q, k_d;
    logic [SW-1:0] best_score_q, best_score_d;
    logic [CW-1:0] best_idx_q, best_idx_d;
    logic [CW-1:0] class_q, class_d;
    logic [SW-1:0] score_q, score_d;
    logic          out_valid_q, out_valid_d;
    logic          overrun_q, overrun_d;
    logic          in_ready_q, in_ready_d;
    logic          busy_q, busy_d;

    logic          capture;
    logic [M-1:0]  w_arr [NW];
    logic [M-1:0]  xnor_bits;
    logic [SW-1:0] score_c;

    // Weight table padded to a power of two so the class counter indexes it directly
    for (genvar j = 0; j < int'(NW); j++) begin : g_w
        if (j < int'(K)) begin : g_used
            assign w_arr[j] = W[j*M +: M];
        end else begin : g_pad
            assign w_arr[j] = '0;
        end
    end

    assign capture   = in_valid & ~prev_valid_q;
    assign xnor_bits = ~(x_q ^ w_arr[k_q]);

    always_comb begin
        score_c = '0;
        for (int i = 0; i < int'(M); i++) begin
            score_c = score_c + SW'(xnor_bits[i]);
        end
    end

    always_comb begin
        state_d      = state_q;
        prev_valid_d = in_valid;
        x_d          = x_q;
        k_d          = k_q;
        best_score_d = best_score_q;
        best_idx_d   = best_idx_q;
        class_d      = class_q;
        score_d      = score_q;
        overrun_d    = overrun_q;

        case (state_q)
            IDLE: begin
                if (capture) begin
                    x_d          = in_bits;
                    k_d          = '0;
                    best_score_d = '0;
                    best_idx_d   = '0;
                    state_d      = SCORE;
                end
            end
            SCORE: begin
                // Strict greater-than keeps the lowest index on ties
                if (k_q == '0 || score_c > best_score_q) begin
                    best_score_d = score_c;
                    best_idx_d   = k_q;
                end
                if (k_q == CW'(K - 1)) begin
                    state_d = DONE;
                end else begin
                    k_d = k_q + CW'(1);
                end
                if (capture) overrun_d = 1'b1;
            end
            DONE: begin
                class_d = best_idx_q;
                score_d = best_score_q;
                state_d = IDLE;
                if (capture) overrun_d = 1'b1;
            end
            default: state_d = IDLE;
        endcase

        out_valid_d = (state_d == DONE);
        in_ready_d  = (state_d == IDLE);
        busy_d      = (state_d != IDLE);
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q      <= IDLE;
            prev_valid_q <= 1'b0;
            x_q          <= '0;
            k_q          <= '0;
            best_score_q <= '0;
            best_idx_q   <= '0;
            class_q      <= '0;
            score_q      <= '0;
            out_valid_q  <= 1'b0;
            overrun_q    <= 1'b0;
            in_ready_q   <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            prev_valid_q <= prev_valid_d;
            x_q          <= x_d;
            k_q          <= k_d;
            best_score_q <= best_score_d;
            best_idx_q   <= best_idx_d;
            class_q      <= class_d;
            score_q      <= score_d;
            out_valid_q  <= out_valid_d;
            overrun_q    <= overrun_d;
            in_ready_q   <= in_ready_d;
            busy_q       <= busy_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign busy      = busy_q;
    assign class_out = class_q;
    assign score_out = score_q;
    assign out_valid = out_valid_q;
    assign overrun   = overrun_q;

endmodule

// File: tb/tb_bnn_argmax_head.sv
// Scoreboard bench for bnn_argmax_head: a 4x4 instance with the reference weights and a
// 7-input, 3-class all-ones instance.
module tb_bnn_argmax_head;

    localparam logic [15:0] WA = 16'h3CAF;

    logic       clk = 1'b0;
    logic       rst;
    logic       in_valid, in_valid_b;
    logic [3:0] in_bits;
    logic [6:0] in_bits_b;
    logic       in_ready, busy, out_valid, overrun;
    logic [1:0] class_out;
    logic [2:0] score_out;
    logic       in_ready_b, busy_b, out_valid_b, overrun_b;
    logic [1:0] class_out_b;
    logic [2:0] score_out_b;

    int n_vec = 0;
    int n_err = 0;
    int cyc   = 0;

    typedef struct {
        logic [1:0] cls;
        logic [2:0] score;
        int         at;
    } exp_t;

    exp_t sbq[$];
    exp_t cur;
    bit   pending = 1'b0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    bnn_argmax_head #(.M(4), .K(4), .W(WA)) u_dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_bits(in_bits),
        .in_ready(in_ready), .busy(busy), .class_out(class_out),
        .score_out(score_out), .out_valid(out_valid), .overrun(overrun)
    );

    bnn_argmax_head #(.M(7), .K(3), .W(21'h1FFFFF)) u_dut_b (
        .clk(clk), .rst(rst), .in_valid(in_valid_b), .in_bits(in_bits_b),
        .in_ready(in_ready_b), .busy(busy_b), .class_out(class_out_b),
        .score_out(score_out_b), .out_valid(out_valid_b), .overrun(overrun_b)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic logic [4:0] model(input logic [3:0] x);
        logic [15:0] wv;
        int best, bi, s;
        wv   = WA;
        best = -1;
        bi   = 0;
        for (int k = 0; k < 4; k++) begin
            s = $countones(~(x ^ wv[k*4 +: 4]));
            if (s > best) begin
                best = s;
                bi   = k;
            end
        end
        return {2'(bi), 3'(best)};
    endfunction

    // Result monitor: pop on the pulse, compare the held result one cycle later
    always @(negedge clk) begin
        if (pending) begin
            check("class_out", 32'(class_out), 32'(cur.cls));
            check("score_out", 32'(score_out), 32'(cur.score));
            pending = 1'b0;
        end
        if (out_valid === 1'b1) begin
            if (sbq.size() == 0) begin
                check("spurious_out_valid", 32'(1), 32'(0));
            end else begin
                cur = sbq.pop_front();
                check("latency", 32'(cyc), 32'(cur.at));
                pending = 1'b1;
            end
        end
    end

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic capture(input logic [3:0] b, input bit push,
                           input logic [1:0] c, input logic [2:0] s);
        exp_t e;
        in_bits  = b;
        in_valid = 1'b1;
        if (push) begin
            e.cls   = c;
            e.score = s;
            e.at    = cyc + 1 + 4;
            sbq.push_back(e);
        end
    endtask

    task automatic wait_done();
        int i = 0;
        while ((sbq.size() != 0 || pending) && i < 30) begin
            tick();
            i++;
        end
        check("drain", 32'(sbq.size()), 32'(0));
    endtask

    initial begin
        logic [4:0] m;
        int c0, i;
        rst = 1'b0; in_valid = 1'b0; in_valid_b = 1'b0; in_bits = '0; in_bits_b = '0;
        repeat (2) tick();
        check("rst_in_ready", 32'(in_ready), 32'(0));
        check("rst_busy", 32'(busy), 32'(0));
        check("rst_out_valid", 32'(out_valid), 32'(0));
        check("rst_overrun", 32'(overrun), 32'(0));
        check("rst_class", 32'(class_out), 32'(0));
        check("rst_score", 32'(score_out), 32'(0));
        rst = 1'b1;
        tick();
        check("in_ready_after_rst", 32'(in_ready), 32'(1));

        // Reference vector and tie
        capture(4'b1100, 1'b1, 2'd2, 3'd4);
        tick(); in_valid = 1'b0;
        check("busy_in_score", 32'(busy), 32'(1));
        check("in_ready_in_score", 32'(in_ready), 32'(0));
        wait_done();
        check("in_ready_after_done", 32'(in_ready), 32'(1));
        capture(4'b0000, 1'b1, 2'd1, 3'd2);
        tick(); in_valid = 1'b0;
        wait_done();

        // Level held high yields one capture
        capture(4'b1100, 1'b1, 2'd2, 3'd4);
        repeat (20) tick();
        in_valid = 1'b0;
        wait_done();
        check("level_overrun", 32'(overrun), 32'(0));

        // Reset two cycles after capture aborts the result
        capture(4'b1100, 1'b0, 2'd0, 3'd0);
        tick(); in_valid = 1'b0;
        tick(); rst = 1'b0;
        tick(); rst = 1'b1;
        check("abort_class", 32'(class_out), 32'(0));
        check("abort_score", 32'(score_out), 32'(0));
        check("abort_in_ready_rst", 32'(in_ready), 32'(0));
        tick();
        check("abort_in_ready", 32'(in_ready), 32'(1));
        repeat (6) tick();
        capture(4'b1100, 1'b1, 2'd2, 3'd4);
        tick(); in_valid = 1'b0;
        wait_done();

        // Second edge while scoring is dropped and flagged
        check("pre_overrun", 32'(overrun), 32'(0));
        capture(4'b0000, 1'b1, 2'd1, 3'd2);
        tick(); in_valid = 1'b0; in_bits = 4'b1100;
        tick(); in_valid = 1'b1;
        tick(); in_valid = 1'b0;
        wait_done();
        check("overrun_set", 32'(overrun), 32'(1));
        repeat (4) tick();
        check("overrun_sticky", 32'(overrun), 32'(1));

        // Reset with in_valid high: capture on the first non-reset edge
        rst = 1'b0; in_valid = 1'b1; in_bits = 4'b1100;
        tick();
        check("overrun_cleared", 32'(overrun), 32'(0));
        rst = 1'b1;
        capture(4'b1100, 1'b1, 2'd2, 3'd4);
        tick(); in_valid = 1'b0;
        wait_done();

        // Every input pattern against the bench model
        for (int v = 0; v < 16; v++) begin
            m = model(4'(v));
            capture(4'(v), 1'b1, m[4:3], m[2:0]);
            tick(); in_valid = 1'b0;
            wait_done();
        end

        // M=7, K=3, all-ones weights
        check("b_in_ready", 32'(in_ready_b), 32'(1));
        in_bits_b = 7'h7F; in_valid_b = 1'b1;
        c0 = cyc;
        tick(); in_valid_b = 1'b0;
        check("b_busy", 32'(busy_b), 32'(1));
        i = 0;
        while (out_valid_b !== 1'b1 && i < 10) begin
            tick();
            i++;
        end
        check("b_latency", 32'(cyc), 32'(c0 + 1 + 3));
        tick();
        check("b_class", 32'(class_out_b), 32'(0));
        check("b_score", 32'(score_out_b), 32'(7));
        check("b_overrun", 32'(overrun_b), 32'(0));

        repeat (3) tick();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/bnn_argmax_head.md
# bnn_argmax_head

Final classification stage of the sequential binarized-network datapath. Sits directly downstream of the sequential hidden-layer engine. It captures that layer's M-bit binary activation vector when the layer raises its completion flag, then scores K output classes one per cycle with XNOR-popcount against hardwired binary weights. It reports the arg-max class index and its score with a one-cycle valid pulse.

## Interface
- M, default 4: width of the input activation vector (hidden-layer neuron count).
- K, default 4: number of output classes, K >= 1.
- W, default all zeros: K*M-bit weight vector; class k's weights are W[k*M +: M]; bit value 1 = +1, 0 = -1.
- Derived: SW = $clog2(M+1) score width; CW = (K>1) ? $clog2(K) : 1 class-index width.

Ports:
- clk  in  1  Single clock, all state on rising edge.
- rst  in  1  Synchronous, active-low reset, sampled on rising edge of clk.
- in_valid  in  1  Upstream completion flag; level signal that may stay high indefinitely.
- in_bits  in  M  Upstream activation vector, valid while in_valid is high.
- in_ready  out  1  High only in IDLE.
- busy  out  1  High in SCORE and DONE.
- class_out  out  CW  Index of the winning class; held until the next result.
- score_out  out  SW  Winning popcount score; held until the next result.
- out_valid  out  1  One-cycle pulse marking a new class_out/score_out.
- overrun  out  1  Sticky flag: a capture edge arrived while busy. Cleared only by reset.

## Operation
- in_valid is edge-qualified.
  - Register prev_valid holds in_valid from the previous cycle.
  - A capture event is in_valid & ~prev_valid.
  - A level held high yields exactly one capture.
- FSM states: IDLE, SCORE, DONE.
  - IDLE: on a capture event, latch x <= in_bits, set k <= 0, best_score <= 0, best_idx <= 0, go to SCORE.
  - SCORE, each cycle:
    - s = popcount(~(x ^ W[k*M +: M])), width SW, range 0..M.
    - If k==0 or s > best_score, set best_score <= s and best_idx <= k. Strict greater-than, so on ties the lowest index wins.
    - If k==K-1, go to DONE; otherwise k <= k+1.
  - DONE (one cycle): class_out <= best_idx, score_out <= best_score, out_valid = 1, go to IDLE.
- Capture events while in SCORE or DONE are dropped (x is unchanged) and set overrun.
- Popcount is purely combinational over M bits. No pipelining inside the score path.
- Reset (rst==0 at a rising edge) does all of the following:
  - state IDLE; prev_valid, x, k, best_score, best_idx cleared.
  - class_out=0, score_out=0, out_valid=0, overrun=0.
  - in_ready is low during the reset cycle and high from the first cycle after rst returns high.
  - Reset mid-SCORE aborts with no out_valid.
- If in_valid is high when reset releases, prev_valid=0 after reset, so it counts as a capture event on the first non-reset edge.

## Timing
- Capture at edge T0.
- SCORE occupies the K cycles after T0; class k is evaluated in the cycle ending at edge T0+1+k.
- DONE occupies the cycle after edge T0+K.
- out_valid is high between edges T0+K and T0+K+1. class_out and score_out are valid from the cycle after edge T0+K+1 and stay stable afterwards.
- Latency from the capture edge to the out_valid pulse is K cycles. Occupancy is K+1 cycles.
- in_ready returns high after edge T0+K+1.
- The earliest next capture is edge T0+K+2 (requires in_valid to fall and rise again).
- K=1: SCORE lasts one cycle and class_out is always 0.

## Test plan
- M=4, K=4, W = {4'b0011, 4'b1100, 4'b1010, 4'b1111} (class3..class0), in_bits=4'b1100, single capture edge:
  - Expected scores 2,2,4,0.
  - Required: out_valid exactly K cycles after the capture edge, class_out=2, score_out=4.
- Tie case, same W, in_bits=4'b0000:
  - Expected scores 0,2,2,2.
  - Required: class_out=1, score_out=2 (lowest index wins).
- Level hold: in_valid high for 20 cycles with in_bits=4'b1100 -> exactly one out_valid pulse, overrun stays 0.
- Reset mid-operation: rst low for one cycle two cycles after capture -> no out_valid; class_out=0, score_out=0, in_ready high after release. A following fresh capture gives the correct result.
- Overrun: in_valid pulses high at the capture edge, low, then high again while in SCORE -> one result only (for the first vector), overrun=1 until reset.
- Parameter sweep M=7, K=3, W all ones, in_bits=7'b1111111 -> class_out=0, score_out=7 after 3 cycles.
